// File: rtl/regfile_loader.sv
// Register-file preload engine: streams bytes into a register file through its write
// port, then reads every entry back through read port A and flags any difference.
//
// state  | meaning
// IDLE   | waiting for Start
// LOAD   | accepting bytes, one register write per handshake
// VERIFY | reading back one address per cycle, comparing against the shadow copy
// DONE   | one-cycle completion pulse
module regfile_loader #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic [D-1:0] RaddrA,
    input  logic [W-1:0] DataOutA,
    output logic         Busy,
    output logic         Done,
    output logic         Mismatch
);

    localparam int         N        = 1 << D;
    localparam logic [D:0] IDX_LAST = {1'b0, {D{1'b1}}};
    localparam logic [D:0] IDX_ONE  = (D + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [D:0]   idx, idx_nxt;
    logic [W-1:0] shadow [N];
    logic         we_q;
    logic [D-1:0] waddr_q;
    logic [W-1:0] din_q;
    logic [D-1:0] raddr_q;
    logic         mismatch_q;
    logic         mm_set;
    logic         mm_clr;
    logic         accept;

    // Abort suppresses a handshake offered in the same cycle.
    assign accept = (state == LOAD) && InValid && !Abort;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mm_set    = 1'b0;
        mm_clr    = 1'b0;
        if (Abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                        mm_clr    = 1'b1;
                    end
                end
                LOAD: begin
                    if (InValid) begin
                        if (idx == IDX_LAST) begin
                            state_nxt = VERIFY;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_ONE;
                        end
                    end
                end
                VERIFY: begin
                    mm_set = (DataOutA != shadow[idx[D-1:0]]);
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            idx        <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            din_q      <= '0;
            raddr_q    <= '0;
            mismatch_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            we_q    <= accept;
            raddr_q <= (state_nxt == VERIFY) ? idx_nxt[D-1:0] : '0;
            if (accept) begin
                waddr_q             <= idx[D-1:0];
                din_q               <= InData;
                shadow[idx[D-1:0]]  <= InData;
            end
            if (mm_clr) begin
                mismatch_q <= 1'b0;
            end else if (mm_set) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign InReady  = (state == LOAD);
    assign Busy     = (state == LOAD) || (state == VERIFY);
    assign Done     = (state == DONE);
    assign WriteEn  = we_q;
    assign Waddr    = waddr_q;
    assign DataIn   = din_q;
    assign RaddrA   = raddr_q;
    assign Mismatch = mismatch_q;

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Register-file preload and readback engine. Accepts a stream of bytes over a valid/ready handshake, writes them into consecutive register-file addresses 0..2**D-1 through the register file's write port, then reads every register back through read port A and flags any mismatch. It sits between the testbench/host byte source and `RegFile`, replacing hard-coded reset constants with run-time initialisation, for example per-program LFSR seeds and taps.

## Interface
Parameters:
- W, 8, data path width; must match RegFile W
- D, 3, register address width; register count is 2**D; D >= 1

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin a load; sampled only in IDLE
- Abort  in  1  synchronous abort; returns to IDLE from any state without pulsing Done
- InValid  in  1  InData holds a valid byte
- InData  in  W  byte to load
- InReady  out  1  loader accepts a byte this cycle; high only in LOAD
- WriteEn  out  1  to RegFile WriteEn; registered
- Waddr  out  D  to RegFile Waddr; registered
- DataIn  out  W  to RegFile DataIn; registered
- RaddrA  out  D  to RegFile RaddrA; registered
- DataOutA  in  W  from RegFile DataOutA; combinational read
- Busy  out  1  high in LOAD and VERIFY
- Done  out  1  one-cycle pulse on completion
- Mismatch  out  1  sticky; set on any readback difference; cleared on accepted Start

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE: Start=1 clears Mismatch and the index counter, then moves to LOAD.
- LOAD: InReady=1. A handshake is InValid & InReady in the same cycle. Each handshake stores InData in a 2**D x W shadow array at the current index and increments the index.
- The handshake on index 2**D-1 moves to VERIFY and resets the index to 0. InValid low means wait, with no timeout.
- VERIFY: RaddrA = index. Each cycle, DataOutA is compared with shadow[index]; if they differ, Mismatch is set. The index increments each cycle. After index 2**D-1 is checked, move to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Mismatch holds until the next accepted Start.
- Start is ignored in LOAD, VERIFY and DONE.
- Abort has priority over every other transition. In the next cycle: state IDLE, WriteEn=0, InReady=0, Done stays 0, and Mismatch is retained. A write already registered for the current cycle still completes.
- The index counter is D+1 bits internally. The terminal compare is against 2**D-1, and the counter never wraps silently.
- The block does not drive RegFile Reset or clr. The integrator must keep RegFile WriteEn from other sources low while Busy=1.

## Timing
- Reset (asserted low) values: state IDLE, InReady=0, WriteEn=0, Waddr=0, DataIn=0, RaddrA=0, Busy=0, Done=0, Mismatch=0, index=0, and the shadow array is all zero.
- Reset mid-operation aborts immediately and asynchronously. No further writes occur.
- Start sampled high at edge k in IDLE gives Busy=1 and InReady=1 from cycle k+1.
- Write latency: a handshake in cycle t gives WriteEn=1, Waddr=index and DataIn=byte during cycle t+1. RegFile captures the byte at the end of t+1.
- WriteEn is high for exactly one cycle per handshake. Back-to-back handshakes give back-to-back writes.
- The last handshake is in cycle t. VERIFY occupies cycles t+1 .. t+2**D, and the final write commits at the end of t+1.
- The first readback (index 0) is in t+1. Index 2**D-1 is read at t+2**D, after its write has committed, so there is no read-after-write hazard for D >= 1.
- DONE is cycle t+2**D+1: Done=1 and Busy=0. Mismatch is valid from this cycle.
- Minimum total load time with InValid held high: 1 + 2**D + 2**D + 1 cycles from Start to the end of Done. That is 18 cycles for D=3.

## Test plan
- Preload: Start, then stream 61,1,0,128,64,73,0,1 with InValid held high. Required: 8 consecutive WriteEn pulses with Waddr 0..7 and matching DataIn. RegFile then holds those values. Done pulses at cycle 18 after Start, and Mismatch=0.
- Backpressure: insert 3 idle InValid=0 cycles between bytes 2 and 3. Required: WriteEn stays low during the gap, no duplicate or skipped addresses, and Done is delayed by exactly 3 cycles.
- Corruption: the bench overrides RegFile DataOutA for address 5 to 0xFF during VERIFY. Required: Mismatch rises the cycle after RaddrA=5, and is still 1 at Done and afterwards. The next Start clears it to 0.
- Start while Busy: pulse Start in LOAD after byte 4. Required: no effect; index continues at 5 and there is exactly one Done.
- Abort during LOAD after 3 bytes. Required: IDLE next cycle, InReady=0, Done never pulses, and only addresses 0..2 are written.
- Reset low mid-VERIFY. Required: all outputs immediately at their reset values and no further WriteEn. After release, a fresh Start completes a full preload normally.
